// File: rtl/mem1_data_memory_responder.sv
// MEM1 responder: one load/store/passthrough at a time against a thread-banked data memory.
// Loads and stores spend MEM_LATENCY cycles in ACCESS; responses are held until resp_ready.
module mem1_data_memory_responder #(
    parameter int DATA_WIDTH        = 64,
    parameter int REG_INDEX_BITS    = 5,
    parameter int THREAD_INDEX_BITS = 3,
    parameter int ADDR_BITS         = 6,
    parameter int MEM_LATENCY       = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_load,
    input  logic                         req_store,
    input  logic [THREAD_INDEX_BITS-1:0] req_thread,
    input  logic [REG_INDEX_BITS-1:0]    req_reg_index,
    input  logic [DATA_WIDTH-1:0]        req_addr,
    input  logic [DATA_WIDTH-1:0]        req_wdata,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [THREAD_INDEX_BITS-1:0] resp_thread,
    output logic [REG_INDEX_BITS-1:0]    resp_reg_index,
    output logic [DATA_WIDTH-1:0]        resp_data,
    output logic                         store_done,
    output logic                         err_both_flags
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    localparam int         IDX_BITS = THREAD_INDEX_BITS + ADDR_BITS;
    localparam int         DEPTH    = 1 << IDX_BITS;
    localparam logic [3:0] LAT_M1   = 4'(MEM_LATENCY - 1);

    logic [1:0]                   state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic                         is_load_q, is_load_d;
    logic [THREAD_INDEX_BITS-1:0] thread_q, thread_d;
    logic [REG_INDEX_BITS-1:0]    reg_q, reg_d;
    logic [ADDR_BITS-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
    logic                         resp_valid_q, resp_valid_d;
    logic [THREAD_INDEX_BITS-1:0] resp_thread_q, resp_thread_d;
    logic [REG_INDEX_BITS-1:0]    resp_reg_q, resp_reg_d;
    logic [DATA_WIDTH-1:0]        resp_data_q, resp_data_d;
    logic                         store_done_q, store_done_d;
    logic                         err_q, err_d;

    logic [DATA_WIDTH-1:0]        mem_q [DEPTH];
    logic [IDX_BITS-1:0]          mem_idx;
    logic [DATA_WIDTH-1:0]        mem_rd;
    logic                         mem_we;
    logic                         unused_addr_hi;

    // Upper address bits are deliberately dropped: accesses wrap within the bank.
    assign unused_addr_hi = ^req_addr[DATA_WIDTH-1:ADDR_BITS];
    assign mem_idx        = {thread_q, addr_q};
    assign mem_rd         = mem_q[mem_idx];
    assign req_ready      = (state_q == S_IDLE);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_load_d     = is_load_q;
        thread_d      = thread_q;
        reg_d         = reg_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        resp_valid_d  = resp_valid_q;
        resp_thread_d = resp_thread_q;
        resp_reg_d    = resp_reg_q;
        resp_data_d   = resp_data_q;
        store_done_d  = 1'b0;
        err_d         = err_q;
        mem_we        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    thread_d  = req_thread;
                    reg_d     = req_reg_index;
                    addr_d    = req_addr[ADDR_BITS-1:0];
                    wdata_d   = req_wdata;
                    is_load_d = req_load;
                    if (req_load && req_store) begin
                        err_d = 1'b1;
                    end
                    if (req_load || req_store) begin
                        state_d = S_ACCESS;
                        cnt_d   = LAT_M1;
                    end else begin
                        state_d       = S_RESPOND;
                        resp_valid_d  = 1'b1;
                        resp_data_d   = req_wdata;
                        resp_thread_d = req_thread;
                        resp_reg_d    = req_reg_index;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (is_load_q) begin
                        state_d       = S_RESPOND;
                        resp_valid_d  = 1'b1;
                        resp_data_d   = mem_rd;
                        resp_thread_d = thread_q;
                        resp_reg_d    = reg_q;
                    end else begin
                        state_d      = S_IDLE;
                        mem_we       = 1'b1;
                        store_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESPOND: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            is_load_q     <= 1'b0;
            thread_q      <= '0;
            reg_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            resp_valid_q  <= 1'b0;
            resp_thread_q <= '0;
            resp_reg_q    <= '0;
            resp_data_q   <= '0;
            store_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_load_q     <= is_load_d;
            thread_q      <= thread_d;
            reg_q         <= reg_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            resp_valid_q  <= resp_valid_d;
            resp_thread_q <= resp_thread_d;
            resp_reg_q    <= resp_reg_d;
            resp_data_q   <= resp_data_d;
            store_done_q  <= store_done_d;
            err_q         <= err_d;
        end
    end

    // Memory is not reset; reset forces state_q to IDLE, so an in-flight store never writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_thread    = resp_thread_q;
    assign resp_reg_index = resp_reg_q;
    assign resp_data      = resp_data_q;
    assign store_done     = store_done_q;
    assign err_both_flags = err_q;

endmodule

// File: doc/mem1_data_memory_responder.md
Name: mem1_data_memory_responder

Overview:
- Responder on the MEM1 side of the EX2/MEM1 boundary: accepts one load/store/ALU-passthrough request per transaction from the EX2/MEM1 pipeline registers.
- Performs the access on a thread-banked internal data memory with fixed multi-cycle latency.
- Returns load results and passthrough values to the writeback path over a valid/ready channel.
- Stores complete silently.

Parameters:
- DATA_WIDTH, 64, width of memory word, store data and response data
- REG_INDEX_BITS, 5, destination register index width
- THREAD_INDEX_BITS, 3, hardware thread index width; the memory has 2**THREAD_INDEX_BITS banks
- ADDR_BITS, 6, word address bits per thread bank (depth 2**ADDR_BITS per bank)
- MEM_LATENCY, 2, ACCESS-state cycles per load/store; legal range 1..15

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_load  input  1  load word (EX2/MEM1 load_word_flag)
- req_store  input  1  store word (EX2/MEM1 store_word_flag)
- req_thread  input  THREAD_INDEX_BITS  issuing thread
- req_reg_index  input  REG_INDEX_BITS  destination register for load/passthrough
- req_addr  input  DATA_WIDTH  word address; only bits [ADDR_BITS-1:0] used
- req_wdata  input  DATA_WIDTH  store data, or ALU result for passthrough
- resp_valid  output  1  response present
- resp_ready  input  1  writeback accepts response
- resp_thread  output  THREAD_INDEX_BITS  thread of response
- resp_reg_index  output  REG_INDEX_BITS  destination register
- resp_data  output  DATA_WIDTH  load data or passthrough value
- store_done  output  1  one-cycle pulse when a store commits
- err_both_flags  output  1  sticky: a request arrived with req_load and req_store both set

Behaviour:
- States: IDLE, ACCESS, RESPOND. req_ready = (state == IDLE), combinational from state only.
- Handshake: a request is accepted at edge T when req_valid && req_ready. All req_* fields are captured into internal registers at T; the inputs may change afterward.
- Classification at acceptance:
  - req_load set -> LOAD (includes the case where both flags are set; err_both_flags is also set).
  - req_store only -> STORE.
  - Neither flag set -> PASS.
- Memory index = {captured thread, captured addr[ADDR_BITS-1:0]}. Upper address bits are ignored (wrap within the bank). Threads never alias each other's banks.
- LOAD/STORE: IDLE -> ACCESS. A down-counter is loaded with MEM_LATENCY-1 and decrements each ACCESS cycle. The memory operation is performed in the ACCESS cycle where the counter reaches 0, i.e. the L-th ACCESS cycle, where L = MEM_LATENCY.
- STORE:
  - Write commits at the edge ending the last ACCESS cycle.
  - store_done = 1 during cycle T+L+1 only.
  - State returns to IDLE, so req_ready = 1 in cycle T+L+1.
  - No response is generated.
- LOAD:
  - Read data is registered at the edge ending the last ACCESS cycle.
  - State moves to RESPOND; resp_valid = 1 from cycle T+L+1.
- PASS: IDLE -> RESPOND directly. resp_valid = 1 from cycle T+1, with resp_data = captured req_wdata.
- RESPOND:
  - resp_valid, resp_thread, resp_reg_index and resp_data are held stable until resp_valid && resp_ready.
  - On that edge: resp_valid -> 0, state -> IDLE; the next request can be accepted one cycle later.
  - resp_ready asserted on the first RESPOND cycle completes the response in exactly 1 cycle.
- Ordering: strictly one outstanding transaction, so a load issued after a store to the same index always returns the stored data.
- resp_* fields are registered outputs. When resp_valid = 0, resp_data, resp_thread and resp_reg_index hold their last values and carry no meaning.
- Reset (asynchronous, any state, including mid-ACCESS or mid-RESPOND):
  - state = IDLE, counter = 0, resp_valid = 0, resp_data = 0, resp_thread = 0, resp_reg_index = 0, store_done = 0, err_both_flags = 0.
  - Captured request registers clear to 0.
  - Memory contents are NOT reset; an in-flight store aborted by reset must not commit.
- err_both_flags is cleared only by reset.

Test Plan:
- Reset → after reset deasserts: req_ready = 1, resp_valid = 0, store_done = 0, all resp_* = 0.
- MEM_LATENCY = 2: store thread 3, addr 5, data 0xDEAD_BEEF_0000_0001 accepted at T → store_done pulses at T+3 only, req_ready = 1 at T+3. Then load thread 3, addr 5, reg 7 accepted at T' → resp_valid at T'+3 with data 0xDEAD_BEEF_0000_0001, reg 7, thread 3.
- Bank isolation/wrap: store thread 1, addr 0x45 (ADDR_BITS = 6, so index 5) = 0x11 → load thread 1, addr 5 returns 0x11; load thread 2, addr 5 returns thread 2's own value, not 0x11.
- Backpressure: load response with resp_ready = 0 for 4 cycles → resp_valid and resp_data held stable; req_ready = 0 throughout; a req_valid presented meanwhile is not accepted until 1 cycle after the resp handshake.
- Passthrough: neither flag set, wdata = 0x1234, reg 9, accepted at T with resp_ready = 1 → resp_valid only at T+1, data 0x1234; next request accepted at T+2.
- Reset mid-operation: store accepted, reset asserted during ACCESS → outputs clear immediately, no store_done, and a subsequent load shows old memory contents. Both flags set on a request → err_both_flags = 1 and the request is handled as a load.
